udivision_recip_seq: RTL and testbench

UDIVISION_RECIP_SEQ -- requirements
Module: udivision_recip_seq

---
 rtl/udivision_recip_seq.sv | 120 ++++++++++++
 tb/tb_udivision_recip_seq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udivision_recip_seq.sv
// Sequential reciprocal: returns round_half_up((2^FRAC_W-1)/(n+1)) using a
// restoring divider that resolves one quotient bit per clock, MSB first.
module udivision_recip_seq #(
  parameter int IN_W   = 8,
  parameter int FRAC_W = 8,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   number_in,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FRAC_W-1:0] reciprocal,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and a presented result holds
  // until it is taken.

  // Width covers d<<FRAC_W (d <= 2^IN_W) and the dividend 2*(2^FRAC_W-1)+d.
  localparam int DW    = IN_W + FRAC_W + 2;
  localparam int CNT_W = $clog2(FRAC_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [DW-1:0]      rem;
  logic [DW-1:0]      dvs;
  logic [FRAC_W-1:0]  quo;
  logic [TAG_W-1:0]   tag_r;
  logic [CNT_W-1:0]   cnt;

  logic [DW-1:0]      d_ext;
  logic [DW-1:0]      rem_init;
  logic [DW-1:0]      dvs_init;
  logic [DW-1:0]      rem_sub;
  logic               ge;
  logic               accept;

  // Rounded division is floor((2M + d) / 2d); the divisor starts aligned to
  // the quotient MSB, i.e. 2d << (FRAC_W-1) == d << FRAC_W.
  assign d_ext    = DW'(number_in) + DW'(1);
  assign rem_init = (DW'({FRAC_W{1'b1}}) << 1) + d_ext;
  assign dvs_init = d_ext << FRAC_W;

  assign ge      = (rem >= dvs);
  assign rem_sub = rem - dvs;

  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rem        <= '0;
      dvs        <= '0;
      quo        <= '0;
      tag_r      <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      reciprocal <= '0;
      out_tag    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rem   <= rem_init;
            dvs   <= dvs_init;
            quo   <= '0;
            tag_r <= in_tag;
            cnt   <= '0;
            state <= DIV;
          end
        end

        DIV: begin
          if (cnt == CNT_W'(FRAC_W)) begin
            // All bits resolved: publish the result on the final DIV edge.
            reciprocal <= quo;
            out_tag    <= tag_r;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            if (ge) begin
              rem <= rem_sub;
            end
            quo <= (quo << 1) | FRAC_W'(ge);
            dvs <= dvs >> 1;
            cnt <= cnt + CNT_W'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udivision_recip_seq.sv
// Bench for udivision_recip_seq: directed corner values, back-pressure, reset
// abort, an exhaustive randomized sweep, and a wide (12/16) instance.
module tb_udivision_recip_seq;

  logic        clk;
  logic        rst;

  // Default instance (IN_W=8, FRAC_W=8, TAG_W=4)
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  number_in;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  reciprocal;
  logic [3:0]  out_tag;
  logic        busy;
  logic [1:0]  state_dbg;

  // Wide instance (IN_W=12, FRAC_W=16, TAG_W=4)
  logic        in_valid_b;
  logic        in_ready_b;
  logic [11:0] number_in_b;
  logic [3:0]  in_tag_b;
  logic        out_valid_b;
  logic        out_ready_b;
  logic [15:0] reciprocal_b;
  logic [3:0]  out_tag_b;
  logic        busy_b;
  logic [1:0]  state_dbg_b;

  int tests_run = 0;
  int tests_failed = 0;

  logic [11:0] exp_q[$];

  udivision_recip_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .number_in(number_in), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .reciprocal(reciprocal), .out_tag(out_tag),
    .busy(busy), .state_dbg(state_dbg)
  );

  udivision_recip_seq #(.IN_W(12), .FRAC_W(16), .TAG_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b),
    .number_in(number_in_b), .in_tag(in_tag_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .reciprocal(reciprocal_b), .out_tag(out_tag_b),
    .busy(busy_b), .state_dbg(state_dbg_b)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: (2^fw - 1) / (n + 1), rounded half-up, in plain integer math.
  function automatic int unsigned ref_q(input int unsigned n, input int unsigned fw);
    longint unsigned m;
    longint unsigned d;
    m = (64'd1 << fw) - 1;
    d = 64'(n) + 1;
    return int'((2 * m + d) / (2 * d));
  endfunction

  // One request on the default instance; returns result, tag and latency.
  task automatic run_a(input int n, input int t, input int stall,
                       output int q, output int qt, output int lat);
    int guard;
    @(negedge clk);
    in_valid  = 1'b1;
    number_in = 8'(n);
    in_tag    = 4'(t);
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    number_in = 8'($urandom);
    in_tag    = 4'($urandom);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    repeat (stall) @(posedge clk);
    #1;
    q  = int'(reciprocal);
    qt = int'(out_tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_b(input int n, input int t, output int q, output int qt, output int lat);
    int guard;
    @(negedge clk);
    in_valid_b  = 1'b1;
    number_in_b = 12'(n);
    in_tag_b    = 4'(t);
    guard = 0;
    while (!in_ready_b && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    in_valid_b  = 1'b0;
    number_in_b = 12'($urandom);
    lat = 0;
    while (!out_valid_b && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    q  = int'(reciprocal_b);
    qt = int'(out_tag_b);
    out_ready_b = 1'b1;
    @(posedge clk);
    #1;
    out_ready_b = 1'b0;
  endtask

  initial begin
    int q, qt, lat, t;
    int dir_n[6]   = '{0, 1, 2, 3, 127, 255};
    int dir_exp[6] = '{255, 128, 85, 64, 2, 1};
    int q0, t0, stable, seen, got, cyc;
    logic [11:0] e;

    // Reset block
    rst = 1'b1;
    in_valid = 1'b0; number_in = '0; in_tag = '0; out_ready = 1'b0;
    in_valid_b = 1'b0; number_in_b = '0; in_tag_b = '0; out_ready_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_recip", 32'(reciprocal), 0);
    check("rst_state", 32'(state_dbg), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_in_ready", 32'(in_ready), 1);

    // Directed corner operands with fixed-latency check
    for (int i = 0; i < 6; i++) begin
      t = $urandom_range(0, 15);
      run_a(dir_n[i], t, 0, q, qt, lat);
      check($sformatf("dir_q_n%0d", dir_n[i]), 32'(q), 32'(dir_exp[i]));
      check($sformatf("dir_lat_n%0d", dir_n[i]), 32'(lat), 9);
      check($sformatf("dir_tag_n%0d", dir_n[i]), 32'(qt), 32'(t));
    end

    // Back-pressure: 20 stalled cycles in DONE with in_valid poked meanwhile
    @(negedge clk);
    in_valid = 1'b1; number_in = 8'd9; in_tag = 4'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("bp_lat", 32'(lat), 9);
    q0 = int'(reciprocal);
    t0 = int'(out_tag);
    check("bp_q", 32'(q0), 32'(ref_q(9, 8)));
    check("bp_tag", 32'(t0), 3);
    stable = 1;
    in_valid = 1'b1; number_in = 8'd77; in_tag = 4'd9;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (!out_valid || int'(reciprocal) != q0 || int'(out_tag) != t0 || in_ready)
        stable = 0;
    end
    in_valid = 1'b0;
    check("bp_stable", 32'(stable), 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_out_valid_drop", 32'(out_valid), 0);
    check("bp_idle_busy", 32'(busy), 0);
    check("bp_idle_ready", 32'(in_ready), 1);
    check("bp_idle_state", 32'(state_dbg), 0);

    // Reset during the 4th DIV cycle aborts the request
    @(negedge clk);
    in_valid = 1'b1; number_in = 8'd200; in_tag = 4'd5;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_recip", 32'(reciprocal), 0);
    check("abort_tag", 32'(out_tag), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_rel_ready", 32'(in_ready), 1);
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    check("abort_no_result", 32'(seen), 0);
    run_a(4, 6, 0, q, qt, lat);
    check("abort_next_q", 32'(q), 51);
    check("abort_next_lat", 32'(lat), 9);
    check("abort_next_tag", 32'(qt), 6);

    // Exhaustive operand sweep with random gaps and random out_ready
    got = 0;
    fork
      begin
        for (int n = 0; n < 256; n++) begin
          int guard;
          int tg;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          @(negedge clk);
          tg = $urandom_range(0, 15);
          in_valid = 1'b1; number_in = 8'(n); in_tag = 4'(tg);
          guard = 0;
          while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
          end
          exp_q.push_back({4'(tg), 8'(ref_q(n, 8))});
          @(posedge clk);
          #1;
          in_valid = 1'b0;
          number_in = 8'($urandom);
          in_tag = 4'($urandom);
        end
      end
      begin
        cyc = 0;
        while (got < 256 && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              check("sweep_unexpected", 32'({out_tag, reciprocal}), 0);
            end else begin
              e = exp_q.pop_front();
              check("sweep_result", 32'({out_tag, reciprocal}), 32'(e));
            end
            got++;
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
      end
    join
    check("sweep_count", 32'(got), 256);

    // Wide instance
    run_b(0, 2, q, qt, lat);
    check("wide_q_n0", 32'(q), 65535);
    check("wide_lat_n0", 32'(lat), 17);
    check("wide_tag_n0", 32'(qt), 2);
    run_b(4095, 11, q, qt, lat);
    check("wide_q_n4095", 32'(q), 16);
    check("wide_lat_n4095", 32'(lat), 17);
    check("wide_tag_n4095", 32'(qt), 11);
    for (int i = 0; i < 8; i++) begin
      int n;
      n = $urandom_range(0, 4095);
      t = $urandom_range(0, 15);
      run_b(n, t, q, qt, lat);
      check("wide_rand_q", 32'(q), 32'(ref_q(n, 16)));
      check("wide_rand_tag", 32'(qt), 32'(t));
    end

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
